alu_issue_scheduler: RTL and testbench

- Reservation-station scheduler in front of the execution-stage ALU. Holds up to DEPTH dispatched ALU ops.
- Captures missing source operands by snooping the ALU result broadcast (tag, result).
- Each cycle, issues the oldest entry with both operands ready to the combinational ALU through the reservation-station output channel.
- Sits between decode/rename dispatch and the ALU. It sequences the single shared ALU among all in-flight ops.

---
 rtl/mips_core_pkg.sv | 55 +++++
 rtl/alu_issue_scheduler_picker.sv | 23 ++
 rtl/alu_issue_scheduler.sv | 126 ++++++++++++
 tb/tb_alu_issue_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared execution-stage types: ALU control encoding and the reservation-station entry.
// The entry layout is sized by the RS_* widths; the scheduler's width parameters default to them.
package mips_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_ctl_t;

  localparam int RS_TAG_WIDTH  = 4;
  localparam int RS_DATA_WIDTH = 32;

  typedef struct packed {
    logic                     valid;
    alu_ctl_t                 alu_ctl;
    logic [RS_TAG_WIDTH-1:0]  tag;
    logic                     op1_rdy;
    logic [RS_DATA_WIDTH-1:0] op1;
    logic [RS_TAG_WIDTH-1:0]  op1_tag;
    logic                     op2_rdy;
    logic [RS_DATA_WIDTH-1:0] op2;
    logic [RS_TAG_WIDTH-1:0]  op2_tag;
  } rs_entry_t;

  // Result-broadcast capture for one entry; untouched if nothing it waits on matches.
  function automatic rs_entry_t rs_wake(input rs_entry_t e,
                                        input logic cdb_valid,
                                        input logic [RS_TAG_WIDTH-1:0] cdb_tag,
                                        input logic [RS_DATA_WIDTH-1:0] cdb_result);
    rs_entry_t r;
    r = e;
    if (e.valid && cdb_valid) begin
      if (!e.op1_rdy && e.op1_tag == cdb_tag) begin
        r.op1_rdy = 1'b1;
        r.op1     = cdb_result;
      end
      if (!e.op2_rdy && e.op2_tag == cdb_tag) begin
        r.op2_rdy = 1'b1;
        r.op2     = cdb_result;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_picker.sv
// Priority encoder over reservation-station ready bits; index 0 (oldest) wins.
module rs_oldest_ready_picker #(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Collapsing-queue reservation station in front of the combinational ALU.
// Entry 0 is the oldest; valid entries stay packed from index 0.
module alu_issue_scheduler
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = RS_TAG_WIDTH,
  parameter int DATA_WIDTH = RS_DATA_WIDTH,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  alu_ctl_t              disp_alu_ctl,
  input  logic [TAG_WIDTH-1:0]  disp_tag,
  input  logic                  disp_op1_rdy,
  input  logic [DATA_WIDTH-1:0] disp_op1,
  input  logic [TAG_WIDTH-1:0]  disp_op1_tag,
  input  logic                  disp_op2_rdy,
  input  logic [DATA_WIDTH-1:0] disp_op2,
  input  logic [TAG_WIDTH-1:0]  disp_op2_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  iss_valid,
  input  logic                  iss_ready,
  output alu_ctl_t              iss_alu_ctl,
  output logic [DATA_WIDTH-1:0] iss_op1,
  output logic [DATA_WIDTH-1:0] iss_op2,
  output logic [TAG_WIDTH-1:0]  iss_tag,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        q     [DEPTH];
  rs_entry_t        q_ext [DEPTH+1];
  rs_entry_t        q_nxt [DEPTH];
  rs_entry_t        new_e;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] wr_idx;
  logic [DEPTH-1:0] req;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             fire;
  logic             disp_fire;
  logic             hit1;
  logic             hit2;

  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++)
      req[i] = q[i].valid & q[i].op1_rdy & q[i].op2_rdy;
  end

  rs_oldest_ready_picker #(.DEPTH(DEPTH)) u_picker (
    .req   (req),
    .found (found),
    .idx   (sel)
  );

  assign occupancy  = occ;
  assign disp_ready = (occ < OCC_W'(DEPTH));
  assign iss_valid  = found;
  assign fire       = found & iss_ready;
  assign disp_fire  = disp_valid & disp_ready;

  always_comb begin
    iss_alu_ctl = alu_ctl_t'(4'd0);
    iss_op1     = '0;
    iss_op2     = '0;
    iss_tag     = '0;
    if (found) begin
      iss_alu_ctl = q[sel].alu_ctl;
      iss_op1     = q[sel].op1;
      iss_op2     = q[sel].op2;
      iss_tag     = q[sel].tag;
    end
  end

  // Incoming op, with same-cycle bypass from the result broadcast.
  always_comb begin
    hit1          = !disp_op1_rdy && cdb_valid && (cdb_tag == disp_op1_tag);
    hit2          = !disp_op2_rdy && cdb_valid && (cdb_tag == disp_op2_tag);
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.alu_ctl = disp_alu_ctl;
    new_e.tag     = disp_tag;
    new_e.op1_rdy = disp_op1_rdy | hit1;
    new_e.op1     = hit1 ? cdb_result : disp_op1;
    new_e.op1_tag = disp_op1_tag;
    new_e.op2_rdy = disp_op2_rdy | hit2;
    new_e.op2     = hit2 ? cdb_result : disp_op2;
    new_e.op2_tag = disp_op2_tag;
  end

  assign wr_idx = occ - OCC_W'(fire);

  // Collapse above the issued slot, then wake, then drop the new op at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      q_ext[i] = q[i];
    q_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (fire && (IDX_W'(i) >= sel)) ? q_ext[i+1] : q_ext[i];
      q_nxt[i] = rs_wake(q_nxt[i], cdb_valid, cdb_tag, cdb_result);
      if (disp_fire && (wr_idx == OCC_W'(i)))
        q_nxt[i] = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
      occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= q_nxt[i];
      occ <= occ + OCC_W'(disp_fire) - OCC_W'(fire);
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: an op-list reference model predicts each
// issue; a negedge monitor pops predictions whenever the DUT hands an op to the ALU.
module tb_alu_issue_scheduler;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  alu_ctl_t    disp_alu_ctl, iss_alu_ctl;
  logic [3:0]  disp_tag, disp_op1_tag, disp_op2_tag, cdb_tag, iss_tag;
  logic        disp_op1_rdy, disp_op2_rdy, cdb_valid, iss_valid, iss_ready;
  logic [31:0] disp_op1, disp_op2, cdb_result, iss_op1, iss_op2;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.DEPTH(DEPTH), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_ctl(disp_alu_ctl),
    .disp_tag(disp_tag), .disp_op1_rdy(disp_op1_rdy), .disp_op1(disp_op1),
    .disp_op1_tag(disp_op1_tag), .disp_op2_rdy(disp_op2_rdy), .disp_op2(disp_op2),
    .disp_op2_tag(disp_op2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_alu_ctl(iss_alu_ctl), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_tag(iss_tag), .occupancy(occupancy)
  );

  typedef struct {
    alu_ctl_t    ctl;
    logic [3:0]  tag;
    bit          r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } op_t;

  typedef struct {
    alu_ctl_t    ctl;
    logic [3:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } iss_t;

  typedef struct {
    bit          rst;
    bit          flush;
    bit          dv;
    op_t         d;
    bit          cv;
    logic [3:0]  ct;
    logic [31:0] cr;
    bit          ir;
  } stim_t;

  op_t  model[$];
  iss_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input alu_ctl_t ctl, input logic [3:0] tag,
                             input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                             input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    op_t o;
    o.ctl = ctl; o.tag = tag;
    o.r1 = r1; o.v1 = v1; o.t1 = t1;
    o.r2 = r2; o.v2 = v2; o.t2 = t2;
    return o;
  endfunction

  function automatic stim_t idle(input bit ir);
    stim_t s;
    s.rst = 0; s.flush = 0; s.dv = 0;
    s.d = mk(ALU_ADDU, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
    s.cv = 0; s.ct = 4'd0; s.cr = 32'd0; s.ir = ir;
    return s;
  endfunction

  // One clock: drive, check registered-state outputs against the model, predict, advance model.
  task automatic step(input stim_t s);
    int   sel;
    bit   can_disp;
    iss_t e;
    op_t  n;
    @(posedge clk); #1;
    rst = s.rst; flush = s.flush; disp_valid = s.dv;
    disp_alu_ctl = s.d.ctl; disp_tag = s.d.tag;
    disp_op1_rdy = s.d.r1; disp_op1 = s.d.v1; disp_op1_tag = s.d.t1;
    disp_op2_rdy = s.d.r2; disp_op2 = s.d.v2; disp_op2_tag = s.d.t2;
    cdb_valid = s.cv; cdb_tag = s.ct; cdb_result = s.cr; iss_ready = s.ir;
    #1;
    sel = -1;
    foreach (model[i]) if (sel < 0 && model[i].r1 && model[i].r2) sel = i;
    chk("occupancy", 64'(occupancy), 64'(model.size()));
    chk("disp_ready", 64'(disp_ready), 64'(model.size() < DEPTH));
    chk("iss_valid", 64'(iss_valid), 64'(sel >= 0));
    if (sel < 0)
      chk("idle_iss_data", 64'(iss_op1 | iss_op2 | {28'd0, iss_tag} | {28'd0, iss_alu_ctl}), 64'd0);
    if (!s.rst && sel >= 0 && s.ir) begin
      e.ctl = model[sel].ctl; e.tag = model[sel].tag;
      e.op1 = model[sel].v1;  e.op2 = model[sel].v2;
      exp_q.push_back(e);
    end
    if (s.rst || s.flush) begin
      model.delete();
    end else begin
      can_disp = model.size() < DEPTH;
      if (sel >= 0 && s.ir) model.delete(sel);
      if (s.cv) begin
        foreach (model[i]) begin
          if (!model[i].r1 && model[i].t1 == s.ct) begin model[i].r1 = 1; model[i].v1 = s.cr; end
          if (!model[i].r2 && model[i].t2 == s.ct) begin model[i].r2 = 1; model[i].v2 = s.cr; end
        end
      end
      if (s.dv && can_disp) begin
        n = s.d;
        if (s.cv && !n.r1 && n.t1 == s.ct) begin n.r1 = 1; n.v1 = s.cr; end
        if (s.cv && !n.r2 && n.t2 == s.ct) begin n.r2 = 1; n.v2 = s.cr; end
        model.push_back(n);
      end
    end
  endtask

  always @(negedge clk) begin
    iss_t e;
    if (rst === 1'b0 && iss_valid === 1'b1 && iss_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got tag %0h want no issue", iss_tag);
      end else begin
        e = exp_q.pop_front();
        chk("issue_tag", 64'(iss_tag), 64'(e.tag));
        chk("issue_ctl", 64'(iss_alu_ctl), 64'(e.ctl));
        chk("issue_op1", 64'(iss_op1), 64'(e.op1));
        chk("issue_op2", 64'(iss_op2), 64'(e.op2));
      end
    end
  end

  initial begin
    stim_t s;
    logic [3:0] tag_ctr;
    rst = 1; flush = 0; disp_valid = 0; disp_alu_ctl = ALU_ADDU; disp_tag = 0;
    disp_op1_rdy = 0; disp_op1 = 0; disp_op1_tag = 0;
    disp_op2_rdy = 0; disp_op2 = 0; disp_op2_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_result = 0; iss_ready = 0;
    repeat (2) @(posedge clk);
    s = idle(1); s.rst = 1; step(s);

    // 1: ready op issues one cycle after dispatch
    s = idle(1); s.dv = 1; s.d = mk(ALU_ADDU, 4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0); step(s);
    repeat (2) step(idle(1));

    // 2: op1 waits on tag 9, woken after three idle cycles
    s = idle(1); s.dv = 1; s.d = mk(ALU_SUBU, 4'd1, 0, 32'd0, 4'd9, 1, 32'd2, 4'd0); step(s);
    repeat (3) step(idle(1));
    s = idle(1); s.cv = 1; s.ct = 4'd9; s.cr = 32'h10; step(s);
    repeat (2) step(idle(1));

    // 3: same-cycle bypass on op2
    s = idle(1); s.dv = 1; s.d = mk(ALU_OR, 4'd2, 1, 32'd1, 4'd0, 0, 32'd0, 4'd5);
    s.cv = 1; s.ct = 4'd5; s.cr = 32'hAB; step(s);
    repeat (2) step(idle(1));

    // 4: fill with iss_ready low, extra dispatch refused, then drain in order
    for (int i = 0; i < 5; i++) begin
      s = idle(0); s.dv = 1;
      s.d = mk(ALU_XOR, 4'(4 + i), 1, 32'(100 + i), 4'd0, 1, 32'(200 + i), 4'd0);
      step(s);
    end
    step(idle(0));
    repeat (5) step(idle(1));

    // 5: blocked oldest, younger ready ones go first, then wake the oldest
    s = idle(0); s.dv = 1; s.d = mk(ALU_AND, 4'd10, 0, 32'd0, 4'd12, 1, 32'h3, 4'd0); step(s);
    s = idle(0); s.dv = 1; s.d = mk(ALU_AND, 4'd11, 1, 32'h11, 4'd0, 1, 32'h22, 4'd0); step(s);
    s = idle(0); s.dv = 1; s.d = mk(ALU_AND, 4'd13, 1, 32'h33, 4'd0, 1, 32'h44, 4'd0); step(s);
    step(idle(1));
    s = idle(1); s.cv = 1; s.ct = 4'd12; s.cr = 32'h55; step(s);
    repeat (3) step(idle(1));

    // 6: flush with concurrent dispatch, then reset mid-operation
    for (int i = 0; i < 3; i++) begin
      s = idle(0); s.dv = 1;
      s.d = mk(ALU_SLT, 4'(i), (i != 0), 32'(i), 4'd15, 1, 32'd9, 4'd0);
      step(s);
    end
    s = idle(1); s.flush = 1; s.dv = 1; s.d = mk(ALU_SLT, 4'd7, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0); step(s);
    step(idle(1));
    for (int i = 0; i < 2; i++) begin
      s = idle(0); s.dv = 1;
      s.d = mk(ALU_NOR, 4'(8 + i), 1, 32'd3, 4'd0, 0, 32'd0, 4'd14);
      step(s);
    end
    s = idle(1); s.rst = 1; step(s);
    step(idle(1));

    // Randomized traffic
    tag_ctr = 4'd0;
    for (int c = 0; c < 600; c++) begin
      s = idle($urandom_range(0, 3) != 0);
      s.rst   = ($urandom_range(0, 199) == 0);
      s.flush = ($urandom_range(0, 49) == 0);
      s.dv    = ($urandom_range(0, 9) < 6);
      s.d = mk(alu_ctl_t'($urandom_range(0, 11)), tag_ctr,
               $urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 7)));
      s.cv = ($urandom_range(0, 1) == 1);
      s.ct = 4'($urandom_range(0, 7));
      s.cr = $urandom;
      tag_ctr = tag_ctr + 4'd1;
      step(s);
    end
    repeat (8) step(idle(1));
    @(negedge clk); #1;
    chk("expected_issues_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
